switch_mcu_wb_arbiter: RTL and testbench

Write-back arbiter that shares the single regfile write port between the ALU execution sub-units (LUI, AUIPC, ADDI, later the R-type, load and CSR units). Each unit raises a valid/ready write request. The arbiter grants one request per cycle in round-robin order, registers it in a one-entry output stage and drives the regfile write port. It sits between the execution sub-units and switch_mcu_regfile, and replaces the fixed-priority write mux in the ALU top.

---
 rtl/switch_mcu_alu_pkg.sv | 23 ++
 rtl/switch_mcu_rr_pick.sv | 31 +++
 rtl/switch_mcu_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_switch_mcu_wb_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_mcu_alu_pkg.sv
// Shared constants and types for the switch_mcu ALU write-back path.
// Holds the regfile geometry, the requester index map and the
// write-back stage FSM encoding.
package switch_mcu_alu_pkg;

   // Regfile geometry; x0 is hard-wired to zero and never written.
   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   localparam int REG_X0 = 0;

   // Requester slots on the write-back arbiter.
   localparam int REQ_LUI   = 0;
   localparam int REQ_AUIPC = 1;
   localparam int REQ_ADDI  = 2;
   localparam int REQ_RTYPE = 3;

   // Write-back output stage: empty or holding one write.
   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } wb_state_t;

endpackage

// File: rtl/switch_mcu_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// found scanning upward from ptr, wrapping from N-1 back to 0.
// Shared by the write-back arbiter and the planned read-port arbiter.
module switch_mcu_rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);

   // Scan the N positions starting at ptr; the first hit wins.
   always_comb begin
      int c;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      c   = 0;
      for (int off = 0; off < N; off++) begin
         c = (int'(ptr) + off) % N;
         if (!any && req[c]) begin
            any    = 1'b1;
            idx    = ($clog2(N))'(c);
            gnt[c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_mcu_wb_arbiter.sv
// Write-back arbiter for the switch_mcu regfile write port.
// Grants one execution sub-unit per cycle in round-robin order, registers
// the granted write in a one-entry stage and drives the regfile port.
// Writes to x0 are accepted and dropped without occupying the stage.
// Optional feature macro: SWITCH_MCU_WB_BYPASS_EN adds two read-address
// compare ports that forward the staged write to the operand read mux.
//
// Handshake: requester i transfers on a cycle where in_req_valid[i] and
// out_req_ready[i] are both high. Ready is a combinational function of
// valid (valid->ready path); requesters hold valid, address and data
// stable until accepted and must never derive valid from ready.
module switch_mcu_wb_arbiter
   import switch_mcu_alu_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int AW   = REG_AW,
   parameter int DW   = REG_DW,
   parameter int CNTW = 16
) (
   input  logic                    in_clk,
   input  logic                    in_rst,
   input  logic [NREQ-1:0]         in_req_valid,
   output logic [NREQ-1:0]         out_req_ready,
   input  logic [NREQ*AW-1:0]      in_req_waddr,
   input  logic [NREQ*DW-1:0]      in_req_wdata,
   input  logic                    in_hold,
`ifdef SWITCH_MCU_WB_BYPASS_EN
   input  logic [AW-1:0]           in_raddr_1,
   input  logic [AW-1:0]           in_raddr_2,
   output logic                    out_byp_hit_1,
   output logic                    out_byp_hit_2,
   output logic [DW-1:0]           out_byp_data_1,
   output logic [DW-1:0]           out_byp_data_2,
`endif
   output logic                    out_wen,
   output logic [AW-1:0]           out_waddr,
   output logic [DW-1:0]           out_wdata,
   output logic [$clog2(NREQ)-1:0] out_grant_id,
   output logic                    out_busy,
   output logic [CNTW-1:0]         out_wr_cnt
);

   localparam int IW = $clog2(NREQ);

   wb_state_t         state;
   wb_state_t         state_nxt;
   logic [IW-1:0]     rr_ptr;
   logic [NREQ-1:0]   pick_gnt;
   logic [IW-1:0]     pick_idx;
   logic              pick_any;
   logic [AW-1:0]     sel_waddr;
   logic [DW-1:0]     sel_wdata;
   logic              can_load;
   logic              grant_en;
   logic              xfer;
   logic              load;

   switch_mcu_rr_pick #(.N(NREQ)) u_pick (
      .req (in_req_valid),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Grant qualification, handshake and regfile write enable. Reset gates
   // both ready and wen so nothing transfers or writes while in_rst is high.
   always_comb begin
      can_load      = (state == S_EMPTY) || ((state == S_FULL) && !in_hold);
      grant_en      = can_load && !in_hold && !in_rst;
      out_req_ready = grant_en ? pick_gnt : '0;
      xfer          = grant_en && pick_any;
      sel_waddr     = in_req_waddr[pick_idx*AW +: AW];
      sel_wdata     = in_req_wdata[pick_idx*DW +: DW];
      load          = xfer && (sel_waddr != AW'(REG_X0));
      out_wen       = (state == S_FULL) && !in_hold && !in_rst;
      out_busy      = (state == S_FULL);
   end

   // Next-state: fill on a non-x0 transfer, drain when a write leaves with
   // nothing to replace it; hold keeps the stage as is.
   always_comb begin
      state_nxt = state;
      case (state)
         S_EMPTY: if (load) state_nxt = S_FULL;
         S_FULL:  if (out_wen && !load) state_nxt = S_EMPTY;
         default: state_nxt = S_EMPTY;
      endcase
   end

   // State register, output stage, round-robin pointer and write counter.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state        <= S_EMPTY;
         rr_ptr       <= '0;
         out_waddr    <= '0;
         out_wdata    <= '0;
         out_grant_id <= '0;
         out_wr_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            if (pick_idx == IW'(NREQ - 1)) rr_ptr <= '0;
            else                           rr_ptr <= pick_idx + 1'b1;
         end
         if (load) begin
            out_waddr    <= sel_waddr;
            out_wdata    <= sel_wdata;
            out_grant_id <= pick_idx;
         end
         if (out_wen && (out_wr_cnt != {CNTW{1'b1}})) begin
            out_wr_cnt <= out_wr_cnt + 1'b1;
         end
      end
   end

`ifdef SWITCH_MCU_WB_BYPASS_EN
   // Forward the staged write to the operand read ports; valid during hold.
   always_comb begin
      out_byp_hit_1  = (state == S_FULL) && (in_raddr_1 == out_waddr) &&
                       (in_raddr_1 != AW'(REG_X0));
      out_byp_hit_2  = (state == S_FULL) && (in_raddr_2 == out_waddr) &&
                       (in_raddr_2 != AW'(REG_X0));
      out_byp_data_1 = out_wdata;
      out_byp_data_2 = out_wdata;
   end
`endif

endmodule

// File: tb/tb_switch_mcu_wb_arbiter.sv
// Testbench for switch_mcu_wb_arbiter: directed scenarios followed by
// randomized traffic, all checked against a reference model that tracks
// the staged write in a queue and the round-robin pointer as an integer.
module tb_switch_mcu_wb_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int CNTW = 16;
   localparam int IW   = 2;
   localparam int EW   = IW + AW + DW;

   // ---------------- clock / reset ----------------
   logic in_clk = 1'b0;
   logic in_rst = 1'b1;
   always #5 in_clk = ~in_clk;

   logic                 in_hold = 1'b0;
   logic [NREQ-1:0]      in_req_valid = '0;
   logic [NREQ-1:0]      out_req_ready;
   logic [NREQ*AW-1:0]   in_req_waddr = '0;
   logic [NREQ*DW-1:0]   in_req_wdata = '0;
   logic                 out_wen;
   logic [AW-1:0]        out_waddr;
   logic [DW-1:0]        out_wdata;
   logic [IW-1:0]        out_grant_id;
   logic                 out_busy;
   logic [CNTW-1:0]      out_wr_cnt;
`ifdef SWITCH_MCU_WB_BYPASS_EN
   logic [AW-1:0]        in_raddr_1 = '0;
   logic [AW-1:0]        in_raddr_2 = '0;
   logic                 out_byp_hit_1, out_byp_hit_2;
   logic [DW-1:0]        out_byp_data_1, out_byp_data_2;
`endif

   switch_mcu_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CNTW(CNTW)) dut (
      .in_clk        (in_clk),
      .in_rst        (in_rst),
      .in_req_valid  (in_req_valid),
      .out_req_ready (out_req_ready),
      .in_req_waddr  (in_req_waddr),
      .in_req_wdata  (in_req_wdata),
      .in_hold       (in_hold),
`ifdef SWITCH_MCU_WB_BYPASS_EN
      .in_raddr_1    (in_raddr_1),
      .in_raddr_2    (in_raddr_2),
      .out_byp_hit_1 (out_byp_hit_1),
      .out_byp_hit_2 (out_byp_hit_2),
      .out_byp_data_1(out_byp_data_1),
      .out_byp_data_2(out_byp_data_2),
`endif
      .out_wen       (out_wen),
      .out_waddr     (out_waddr),
      .out_wdata     (out_wdata),
      .out_grant_id  (out_grant_id),
      .out_busy      (out_busy),
      .out_wr_cnt    (out_wr_cnt)
   );

   // ---------------- requester-side stimulus state ----------------
   logic          rv[NREQ];
   logic [AW-1:0] ra[NREQ];
   logic [DW-1:0] rd[NREQ];

   // ---------------- reference model / scoreboard ----------------
   logic [EW-1:0]   exp_q[$];   // staged write {grant, waddr, wdata}
   int              m_ptr;
   int              m_cnt;
   logic [NREQ-1:0] m_ready;
   int              n_cmp;
   int              n_err;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver: one clock cycle ----------------
   // Called at a negedge: apply inputs, check against the model, advance
   // across the posedge, update the model, return at the next negedge.
   task automatic tick();
      int            g;
      int            c;
      logic          exp_busy;
      logic          exp_wen;
      logic [EW-1:0] head;
      for (int i = 0; i < NREQ; i++) begin
         in_req_valid[i]          = rv[i];
         in_req_waddr[i*AW +: AW] = ra[i];
         in_req_wdata[i*DW +: DW] = rd[i];
      end
      exp_busy = (exp_q.size() != 0);
      head     = exp_busy ? exp_q[0] : '0;
`ifdef SWITCH_MCU_WB_BYPASS_EN
      in_raddr_1 = ($urandom_range(0, 1) == 1) ? head[DW +: AW] : AW'($urandom);
      in_raddr_2 = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
`endif
      #1;
      g = -1;
      if (!in_rst && !in_hold) begin
         for (int k = 0; k < NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (g < 0 && rv[c]) g = c;
         end
      end
      m_ready = '0;
      if (g >= 0) m_ready[g] = 1'b1;
      exp_wen = exp_busy && !in_hold && !in_rst;

      check("ready", 64'(out_req_ready), 64'(m_ready));
      check("wen",   64'(out_wen),       64'(exp_wen));
      check("busy",  64'(out_busy),      64'(exp_busy));
      check("wr_cnt", 64'(out_wr_cnt),   64'(m_cnt));
      if (exp_busy) begin
         check("grant_id", 64'(out_grant_id), 64'(head[EW-1 -: IW]));
         check("waddr",    64'(out_waddr),    64'(head[DW +: AW]));
         check("wdata",    64'(out_wdata),    64'(head[DW-1:0]));
      end
`ifdef SWITCH_MCU_WB_BYPASS_EN
      check("byp_hit_1", 64'(out_byp_hit_1),
            64'(exp_busy && in_raddr_1 == head[DW +: AW] && in_raddr_1 != 0));
      check("byp_hit_2", 64'(out_byp_hit_2),
            64'(exp_busy && in_raddr_2 == head[DW +: AW] && in_raddr_2 != 0));
      if (exp_busy) check("byp_data_1", 64'(out_byp_data_1), 64'(head[DW-1:0]));
`endif

      @(posedge in_clk);
      if (in_rst) begin
         exp_q.delete();
         m_ptr = 0;
         m_cnt = 0;
      end else begin
         if (exp_wen) begin
            void'(exp_q.pop_front());
            if (m_cnt < (1 << CNTW) - 1) m_cnt++;
         end
         if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            if (ra[g] != 0) exp_q.push_back({IW'(g), ra[g], rd[g]});
         end
      end
      @(negedge in_clk);
   endtask

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      rv[i] = v;
      ra[i] = a;
      rd[i] = d;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_cmp = 0;
      n_err = 0;
      m_ptr = 0;
      m_cnt = 0;
      m_ready = '0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), DW'($urandom));

      // First reset edge brings the DUT out of its power-up state unchecked.
      in_rst = 1'b1;
      @(posedge in_clk);
      @(negedge in_clk);

      // Reset with every requester valid: nothing granted or written.
      tick();
      tick();
      check("rst_waddr", 64'(out_waddr), 64'd0);
      in_rst = 1'b0;
      tick();
      check("first_gid", 64'(out_grant_id), 64'd0);
      check("first_wen", 64'(out_wen), 64'd1);

      // Back-to-back: requester 0 alone, one write per cycle.
      in_rst = 1'b1;
      tick();
      in_rst = 1'b0;
      clear_reqs();
      set_req(0, 1'b1, 5'd5, 32'h1234_5000);
      for (int j = 0; j < 4; j++) tick();
      check("b2b_waddr", 64'(out_waddr), 64'd5);
      check("b2b_wdata", 64'(out_wdata), 64'h1234_5000);
      check("b2b_cnt",   64'(out_wr_cnt), 64'd3);

      // Fairness: all four valid for 8 cycles from a fresh pointer.
      in_rst = 1'b1;
      tick();
      in_rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(10 + i), DW'($urandom));
      for (int j = 0; j < 8; j++) begin
         tick();
         check("fair_gid", 64'(out_grant_id), 64'(j % NREQ));
      end
      clear_reqs();
      tick();
      check("fair_cnt", 64'(out_wr_cnt), 64'd8);

      // x0 drop: requester 2 writes x0; the next grant starts at 3.
      set_req(2, 1'b1, 5'd0, 32'hFFFF_FFFF);
      tick();
      clear_reqs();
      tick();
      check("x0_cnt", 64'(out_wr_cnt), 64'd8);
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(20 + i), DW'($urandom));
      tick();
      check("x0_next_gid", 64'(out_grant_id), 64'd3);

      // Hold: stage full with waddr 7 held for 3 cycles, then released.
      clear_reqs();
      tick();
      set_req(1, 1'b1, 5'd7, 32'hCAFE_0007);
      tick();
      set_req(1, 1'b0, '0, '0);
      set_req(0, 1'b1, 5'd3, 32'h0000_0303);
      in_hold = 1'b1;
      for (int j = 0; j < 3; j++) tick();
      check("hold_waddr", 64'(out_waddr), 64'd7);
      in_hold = 1'b0;
      tick();
      check("hold_next_gid", 64'(out_grant_id), 64'd0);

      // Mid-operation reset with a staged write (waddr 9).
      clear_reqs();
      tick();
      set_req(3, 1'b1, 5'd9, 32'h0000_0909);
      tick();
      clear_reqs();
      in_rst = 1'b1;
      tick();
      in_rst = 1'b0;
      check("midrst_wen",  64'(out_wen),  64'd0);
      check("midrst_busy", 64'(out_busy), 64'd0);
      tick();

      // Randomized traffic; requesters hold their request until accepted.
      for (int j = 0; j < 1500; j++) begin
         in_hold = ($urandom_range(0, 4) == 0);
         in_rst  = ($urandom_range(0, 199) == 0);
         tick();
         for (int i = 0; i < NREQ; i++) begin
            if (m_ready[i] || !rv[i]) begin
               set_req(i, ($urandom_range(0, 99) < 60),
                       ($urandom_range(0, 9) == 0) ? AW'(0) : AW'($urandom),
                       DW'($urandom));
            end
         end
      end
      in_hold = 1'b0;
      in_rst  = 1'b0;
      clear_reqs();
      tick();
      tick();

      // ---------------- final report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
